// File: rtl/arb_mux.sv
// arb_mux: registered N-to-1 selector with round-robin arbitration and a
// valid/ready handshake on every channel.
//
// Compile-time option:
//   ARB_MUX_FIXED_PRIO_EN - when defined, the lowest-index valid channel
//                           always wins and the rotating pointer is removed.
//                           Undefined (default): round-robin from ptr.
//
// IN_READY is combinational from IN_VALID, OUT_READY and FLUSH; every OUT_*
// signal comes straight from a flop.
module arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
    input  logic                    FLUSH,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [SEL_W-1:0]        OUT_SRC,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    logic              load;
    logic [SEL_W-1:0]  scan_start;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [WIDTH-1:0]  sel_data;

    // The output register can take a new beat when it is empty or being
    // drained this edge; a flush blocks loading even if the consumer is ready.
    assign load = !FLUSH && (!OUT_VALID || OUT_READY);

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [SEL_W-1:0] ptr;

    assign scan_start = ptr;

    // Rotating priority pointer: moves just past the channel that transferred.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (load && grant_any) begin
            ptr <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Scan channels starting at scan_start, wrapping modulo NUM_IN; the first
    // valid channel found wins.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_sel;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(scan_start) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            idx_sel = SEL_W'(idx);
            if (!grant_any && IN_VALID[idx_sel]) begin
                grant_any      = 1'b1;
                grant_idx      = idx_sel;
                grant[idx_sel] = 1'b1;
            end
        end
    end

    assign IN_READY = load ? grant : '0;
    assign sel_data = IN_DATA[grant_idx*WIDTH +: WIDTH];

    // Output register: load on transfer, empty on idle load or flush, hold on stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_DATA  <= '0;
            OUT_SRC   <= '0;
            OUT_VALID <= 1'b0;
        end else if (load) begin
            if (grant_any) begin
                OUT_DATA  <= sel_data;
                OUT_SRC   <= grant_idx;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N-to-1 selector with built-in round-robin arbitration and a valid/ready handshake on every port. It generalises the pipeline's fixed-select multiplexers into a shared-resource front end. Example uses: merging instruction-fetch, data and debug requests onto a single memory port, or funnelling several writeback sources into one register-file write port. One output register stage decouples the requesters from the consumer.

## Interface
- `WIDTH`, 32, data width of each channel
- `NUM_IN`, 4, number of input channels (2..16)
- `SEL_W`, `$clog2(NUM_IN)`, width of the source index
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `IN_DATA`  in  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- `IN_VALID`  in  NUM_IN  per-channel request
- `IN_READY`  out  NUM_IN  per-channel accept (one-hot or zero)
- `FLUSH`  in  1  discard the held output and block acceptance this cycle
- `OUT_DATA`  out  WIDTH  registered selected data
- `OUT_SRC`  out  SEL_W  index of the channel that produced `OUT_DATA`
- `OUT_VALID`  out  1  output register holds a beat
- `OUT_READY`  in  1  consumer accepts the beat

## Operation
- Internal state:
  - output register {`OUT_DATA`, `OUT_SRC`, `OUT_VALID`}
  - priority pointer `ptr` [SEL_W-1:0]
- The register can load when `load = !FLUSH && (!OUT_VALID || OUT_READY)`.
- Grant selection:
  - Scan channels `ptr`, `ptr+1`, …, wrapping modulo NUM_IN.
  - The first i with `IN_VALID[i]=1` is granted.
  - `IN_READY[i] = load && grant[i]`. This is combinational from `IN_VALID`, `OUT_READY` and `FLUSH`; at most one bit is set.
- Transfer on input i happens when `IN_VALID[i] && IN_READY[i]`. At the next edge:
  - `OUT_DATA` ← channel i data
  - `OUT_SRC` ← i
  - `OUT_VALID` ← 1
  - `ptr` ← (i+1) mod NUM_IN, wrapping NUM_IN-1 → 0
- `load` with no request: `OUT_VALID` ← 0, `ptr` unchanged, `OUT_DATA`/`OUT_SRC` hold their last values.
- Output stalled (`OUT_VALID && !OUT_READY`, no FLUSH): all outputs hold, all `IN_READY` = 0.
- `FLUSH`:
  - Next edge `OUT_VALID` ← 0.
  - No input is accepted that cycle; `ptr` is unchanged.
  - FLUSH overrides `OUT_READY`; the beat counts as dropped, not delivered.
- Requesters must hold `IN_VALID`/data stable until accepted. The block does not check this.
- Reset (asynchronous assert, synchronous-edge release): `OUT_VALID`=0, `OUT_DATA`=0, `OUT_SRC`=0, `ptr`=0. Reset mid-transfer drops the held beat.

## Timing
- Latency: 1 cycle from input transfer to `OUT_VALID`.
- Throughput: 1 beat/cycle while `OUT_READY`=1, because a drain and a load occur in the same edge.
- Fairness: with every channel continuously valid, each channel is granted exactly once per NUM_IN cycles.
- Combinational paths:
  - `IN_VALID` → `IN_READY`
  - `OUT_READY` → `IN_READY`
  - `FLUSH` → `IN_READY`
- No combinational path from any input to `OUT_*`.

## Configuration
- `ARB_MUX_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest-index valid channel always wins.
  - `ptr` logic is not compiled and the scan starts at 0.
  - Everything else is identical.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: assert `RST` mid-beat with `OUT_VALID`=1 → `OUT_VALID`, `OUT_DATA`, `OUT_SRC`, `ptr` are all 0 immediately (asynchronous); after release, the first grant goes to channel 0.
- Round-robin: NUM_IN=4, all valid, channel data 0xA0..0xA3, `OUT_READY`=1 → `OUT_SRC` sequence 0,1,2,3,0,1,…; `OUT_DATA` 0xA0,0xA1,…; one beat per cycle.
- Sparse wrap: only channels 1 and 3 valid, `ptr`=2 → grant 3, then 1, then 3; `ptr` wraps 3→0 and the scan skips the idle channels 0 and 2.
- Back-pressure: `OUT_READY`=0 for 3 cycles with `OUT_VALID`=1 → `OUT_DATA`/`OUT_SRC` stable, `IN_READY`=0; on `OUT_READY`=1 the next channel transfers the same cycle.
- Flush: `OUT_VALID`=1, channel 2 valid, `FLUSH`=1 for one cycle → `IN_READY`=0 that cycle, `OUT_VALID`=0 next cycle, `ptr` unchanged; channel 2 is accepted the following cycle.
- With `ARB_MUX_FIXED_PRIO_EN`: channels 0 and 2 continuously valid → `OUT_SRC` is 0 every cycle and channel 2 is never granted.
